// File: rtl/nx_node_decoder.sv
// nx_node_decoder: splits inbound node messages into instruction loads,
// I/O mapping updates and signal-state updates. Instruction loads go through
// a single-entry buffer; map/signal updates are one-cycle registered pulses.
module nx_node_decoder #(
    parameter int STREAM_WIDTH   = 32,
    parameter int ADDR_ROW_WIDTH = 4,
    parameter int ADDR_COL_WIDTH = 4,
    parameter int COMMAND_WIDTH  = 2,
    parameter int INPUTS         = 8,
    parameter int OUTPUTS        = 8,
    localparam int MAX_IO        = (INPUTS > OUTPUTS) ? INPUTS : OUTPUTS,
    localparam int IO_W          = (MAX_IO > 1) ? $clog2(MAX_IO) : 1,
    localparam int IDX_W         = (OUTPUTS > 1) ? $clog2(OUTPUTS) : 1,
    localparam int PAYLOAD_WIDTH = STREAM_WIDTH - 1 - ADDR_ROW_WIDTH - ADDR_COL_WIDTH - COMMAND_WIDTH
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [STREAM_WIDTH-1:0]   msg_data_i,
    input  logic                      msg_valid_i,
    output logic                      msg_ready_o,
    output logic [PAYLOAD_WIDTH-1:0]  instr_data_o,
    output logic                      instr_valid_o,
    input  logic                      instr_ready_i,
    output logic [IO_W-1:0]           map_io_o,
    output logic                      map_input_o,
    output logic [ADDR_ROW_WIDTH-1:0] map_remote_row_o,
    output logic [ADDR_COL_WIDTH-1:0] map_remote_col_o,
    output logic [IDX_W-1:0]          map_remote_idx_o,
    output logic                      map_slot_o,
    output logic                      map_broadcast_o,
    output logic                      map_seq_o,
    output logic                      map_valid_o,
    output logic [ADDR_ROW_WIDTH-1:0] signal_remote_row_o,
    output logic [ADDR_COL_WIDTH-1:0] signal_remote_col_o,
    output logic [IDX_W-1:0]          signal_remote_idx_o,
    output logic                      signal_state_o,
    output logic                      signal_valid_o,
    output logic [7:0]                drop_count_o,
    output logic                      idle_o
);

    typedef struct packed {
        logic [IO_W-1:0]           io;
        logic                      inp;
        logic [ADDR_ROW_WIDTH-1:0] row;
        logic [ADDR_COL_WIDTH-1:0] col;
        logic [IDX_W-1:0]          idx;
        logic                      slot;
        logic                      bcast;
        logic                      seq;
    } cfg_t;

    typedef struct packed {
        logic [ADDR_ROW_WIDTH-1:0] row;
        logic [ADDR_COL_WIDTH-1:0] col;
        logic [IDX_W-1:0]          idx;
        logic                      state;
    } sig_t;

    localparam int CFG_BITS = $bits(cfg_t);
    localparam int SIG_BITS = $bits(sig_t);

    localparam logic [COMMAND_WIDTH-1:0] CMD_LOAD = COMMAND_WIDTH'(0);
    localparam logic [COMMAND_WIDTH-1:0] CMD_CFG  = COMMAND_WIDTH'(1);
    localparam logic [COMMAND_WIDTH-1:0] CMD_SIG  = COMMAND_WIDTH'(2);

    // Message fields; broadcast/row/col header is already consumed by the router.
    logic [COMMAND_WIDTH-1:0] cmd;
    logic [PAYLOAD_WIDTH-1:0] payload;
    cfg_t                     cfg_in;
    sig_t                     sig_in;
    logic [STREAM_WIDTH-PAYLOAD_WIDTH-COMMAND_WIDTH-1:0] unused_hdr;

    assign payload    = msg_data_i[PAYLOAD_WIDTH-1:0];
    assign cmd        = msg_data_i[PAYLOAD_WIDTH +: COMMAND_WIDTH];
    assign unused_hdr = msg_data_i[STREAM_WIDTH-1:PAYLOAD_WIDTH+COMMAND_WIDTH];
    assign cfg_in     = payload[PAYLOAD_WIDTH-1 -: CFG_BITS];
    assign sig_in     = payload[PAYLOAD_WIDTH-1 -: SIG_BITS];

    logic                     instr_valid_q, instr_valid_d;
    logic [PAYLOAD_WIDTH-1:0] instr_data_q,  instr_data_d;
    logic                     map_valid_q,   map_valid_d;
    cfg_t                     cfg_q,         cfg_d;
    logic                     sig_valid_q,   sig_valid_d;
    sig_t                     sig_q,         sig_d;
    logic [7:0]               drop_q,        drop_d;
    logic                     accept;

    // A held instruction blocks every command so message order is preserved.
    assign msg_ready_o = !instr_valid_q || instr_ready_i;
    assign accept      = msg_valid_i && msg_ready_o;

    // Next-state: drain the instruction buffer, then apply the accepted command.
    always_comb begin
        instr_valid_d = instr_valid_q && !instr_ready_i;
        instr_data_d  = instr_data_q;
        map_valid_d   = 1'b0;
        cfg_d         = cfg_q;
        sig_valid_d   = 1'b0;
        sig_d         = sig_q;
        drop_d        = drop_q;
        if (accept) begin
            case (cmd)
                CMD_LOAD: begin
                    instr_valid_d = 1'b1;
                    instr_data_d  = payload;
                end
                CMD_CFG: begin
                    map_valid_d = 1'b1;
                    cfg_d       = cfg_in;
                end
                CMD_SIG: begin
                    sig_valid_d = 1'b1;
                    sig_d       = sig_in;
                end
                default: begin
                    if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
                end
            endcase
        end
    end

    // State registers; reset clears any buffered instruction or pending pulse.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            instr_valid_q <= 1'b0;
            instr_data_q  <= '0;
            map_valid_q   <= 1'b0;
            cfg_q         <= '0;
            sig_valid_q   <= 1'b0;
            sig_q         <= '0;
            drop_q        <= '0;
        end else begin
            instr_valid_q <= instr_valid_d;
            instr_data_q  <= instr_data_d;
            map_valid_q   <= map_valid_d;
            cfg_q         <= cfg_d;
            sig_valid_q   <= sig_valid_d;
            sig_q         <= sig_d;
            drop_q        <= drop_d;
        end
    end

    assign instr_valid_o       = instr_valid_q;
    assign instr_data_o        = instr_data_q;
    assign map_valid_o         = map_valid_q;
    assign map_io_o            = cfg_q.io;
    assign map_input_o         = cfg_q.inp;
    assign map_remote_row_o    = cfg_q.row;
    assign map_remote_col_o    = cfg_q.col;
    assign map_remote_idx_o    = cfg_q.idx;
    assign map_slot_o          = cfg_q.slot;
    assign map_broadcast_o     = cfg_q.bcast;
    assign map_seq_o           = cfg_q.seq;
    assign signal_valid_o      = sig_valid_q;
    assign signal_remote_row_o = sig_q.row;
    assign signal_remote_col_o = sig_q.col;
    assign signal_remote_idx_o = sig_q.idx;
    assign signal_state_o      = sig_q.state;
    assign drop_count_o        = drop_q;
    assign idle_o              = !instr_valid_q && !map_valid_q && !sig_valid_q && !msg_valid_i;

endmodule

// File: tb/tb_nx_node_decoder.sv
// tb_nx_node_decoder: directed scenarios plus randomized traffic, checked every
// cycle against a message-level model of the decoder.
module tb_nx_node_decoder;
    localparam int PW = 21;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [31:0] msg_data_i = '0;
    logic        msg_valid_i = 1'b0;
    logic        msg_ready_o;
    logic [PW-1:0] instr_data_o;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b0;
    logic [2:0]  map_io_o;
    logic        map_input_o;
    logic [3:0]  map_remote_row_o, map_remote_col_o;
    logic [2:0]  map_remote_idx_o;
    logic        map_slot_o, map_broadcast_o, map_seq_o, map_valid_o;
    logic [3:0]  signal_remote_row_o, signal_remote_col_o;
    logic [2:0]  signal_remote_idx_o;
    logic        signal_state_o, signal_valid_o;
    logic [7:0]  drop_count_o;
    logic        idle_o;

    nx_node_decoder dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .msg_data_i(msg_data_i), .msg_valid_i(msg_valid_i), .msg_ready_o(msg_ready_o),
        .instr_data_o(instr_data_o), .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
        .map_io_o(map_io_o), .map_input_o(map_input_o), .map_remote_row_o(map_remote_row_o),
        .map_remote_col_o(map_remote_col_o), .map_remote_idx_o(map_remote_idx_o),
        .map_slot_o(map_slot_o), .map_broadcast_o(map_broadcast_o), .map_seq_o(map_seq_o),
        .map_valid_o(map_valid_o),
        .signal_remote_row_o(signal_remote_row_o), .signal_remote_col_o(signal_remote_col_o),
        .signal_remote_idx_o(signal_remote_idx_o), .signal_state_o(signal_state_o),
        .signal_valid_o(signal_valid_o),
        .drop_count_o(drop_count_o), .idle_o(idle_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Message builders: random header, command, payload fields packed MSB-first.
    function automatic logic [31:0] mk(input int cmd, input logic [PW-1:0] p);
        logic [8:0] hdr;
        logic [1:0] c;
        hdr = 9'($urandom);
        c   = 2'(cmd);
        return {hdr, c, p};
    endfunction

    function automatic logic [PW-1:0] cfgp(input int io, inp, row, col, idx, slot, bc, seq);
        return PW'((io << 18) | (inp << 17) | (row << 13) | (col << 9) |
                   (idx << 6) | (slot << 5) | (bc << 4) | (seq << 3));
    endfunction

    function automatic logic [PW-1:0] sigp(input int row, col, idx, st);
        return PW'((row << 17) | (col << 13) | (idx << 10) | (st << 9));
    endfunction

    // Message-level reference model.
    int m_iv, m_id, m_mv, m_sv, m_drop;
    int m_io, m_inp, m_mrow, m_mcol, m_midx, m_slot, m_bc, m_seq;
    int m_srow, m_scol, m_sidx, m_st;
    int m_cmd, m_pay;
    logic m_acc;

    assign m_cmd = int'(msg_data_i[22:21]);
    assign m_pay = int'(msg_data_i[PW-1:0]);
    assign m_acc = msg_valid_i && (m_iv == 0 || instr_ready_i);

    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            m_iv <= 0; m_id <= 0; m_mv <= 0; m_sv <= 0; m_drop <= 0;
            m_io <= 0; m_inp <= 0; m_mrow <= 0; m_mcol <= 0; m_midx <= 0;
            m_slot <= 0; m_bc <= 0; m_seq <= 0;
            m_srow <= 0; m_scol <= 0; m_sidx <= 0; m_st <= 0;
        end else begin
            cyc <= cyc + 1;
            m_mv <= 0;
            m_sv <= 0;
            if (m_iv != 0 && instr_ready_i) m_iv <= 0;
            if (m_acc) begin
                if (m_cmd == 0) begin
                    m_iv <= 1;
                    m_id <= m_pay;
                end else if (m_cmd == 1) begin
                    m_mv   <= 1;
                    m_io   <= (m_pay >> 18) % 8;
                    m_inp  <= (m_pay >> 17) % 2;
                    m_mrow <= (m_pay >> 13) % 16;
                    m_mcol <= (m_pay >> 9) % 16;
                    m_midx <= (m_pay >> 6) % 8;
                    m_slot <= (m_pay >> 5) % 2;
                    m_bc   <= (m_pay >> 4) % 2;
                    m_seq  <= (m_pay >> 3) % 2;
                end else if (m_cmd == 2) begin
                    m_sv   <= 1;
                    m_srow <= (m_pay >> 17) % 16;
                    m_scol <= (m_pay >> 13) % 16;
                    m_sidx <= (m_pay >> 10) % 8;
                    m_st   <= (m_pay >> 9) % 2;
                end else begin
                    m_drop <= (m_drop < 255) ? m_drop + 1 : 255;
                end
            end
        end
    end

    // Mid-cycle comparison of every output against the model.
    always @(negedge clk_i) begin
        chk("msg_ready",   64'(msg_ready_o),   64'(m_iv == 0 || instr_ready_i));
        chk("instr_valid", 64'(instr_valid_o), 64'(m_iv));
        chk("instr_data",  64'(instr_data_o),  64'(m_id));
        chk("map_valid",   64'(map_valid_o),   64'(m_mv));
        chk("map_io",      64'(map_io_o),      64'(m_io));
        chk("map_input",   64'(map_input_o),   64'(m_inp));
        chk("map_row",     64'(map_remote_row_o), 64'(m_mrow));
        chk("map_col",     64'(map_remote_col_o), 64'(m_mcol));
        chk("map_idx",     64'(map_remote_idx_o), 64'(m_midx));
        chk("map_slot",    64'(map_slot_o),    64'(m_slot));
        chk("map_bc",      64'(map_broadcast_o), 64'(m_bc));
        chk("map_seq",     64'(map_seq_o),     64'(m_seq));
        chk("sig_valid",   64'(signal_valid_o), 64'(m_sv));
        chk("sig_row",     64'(signal_remote_row_o), 64'(m_srow));
        chk("sig_col",     64'(signal_remote_col_o), 64'(m_scol));
        chk("sig_idx",     64'(signal_remote_idx_o), 64'(m_sidx));
        chk("sig_state",   64'(signal_state_o), 64'(m_st));
        chk("drop_count",  64'(drop_count_o),  64'(m_drop));
        chk("idle",        64'(idle_o), 64'(m_iv == 0 && m_mv == 0 && m_sv == 0 && !msg_valid_i));
    end

    // Present a message from posedge+1 and return at posedge+1 after the accepting edge.
    task automatic send(input logic [31:0] d);
        logic acc;
        msg_valid_i = 1'b1;
        msg_data_i  = d;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk_i);
            acc = msg_ready_o;
            @(posedge clk_i);
            #1;
            if (acc) begin
                msg_valid_i = 1'b0;
                return;
            end
        end
        msg_valid_i = 1'b0;
        chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        int c0;
        // Reset state
        #2;
        chk("rst_instr_valid", 64'(instr_valid_o), 64'd0);
        chk("rst_msg_ready",   64'(msg_ready_o),   64'd1);
        chk("rst_idle",        64'(idle_o),        64'd1);
        chk("rst_drop",        64'(drop_count_o),  64'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        tick();

        // SIG_STATE row 2, col 3, idx 5, state 1
        instr_ready_i = 1'b1;
        send(mk(2, sigp(2, 3, 5, 1)));
        chk("sig_pulse", 64'(signal_valid_o), 64'd1);
        chk("sig_fields", 64'({signal_remote_row_o, signal_remote_col_o, signal_remote_idx_o, signal_state_o}),
            64'({4'd2, 4'd3, 3'd5, 1'b1}));
        tick();
        chk("sig_pulse_end", 64'(signal_valid_o), 64'd0);
        chk("sig_fields_held", 64'(signal_remote_idx_o), 64'd5);

        // CFG_IO io 4, input 1, row 1, col 0, idx 7, seq 1
        send(mk(1, cfgp(4, 1, 1, 0, 7, 0, 0, 1)));
        chk("map_pulse", 64'(map_valid_o), 64'd1);
        chk("map_fields", 64'({map_io_o, map_input_o, map_remote_row_o, map_remote_col_o,
                               map_remote_idx_o, map_slot_o, map_seq_o}),
            64'({3'd4, 1'b1, 4'd1, 4'd0, 3'd7, 1'b0, 1'b1}));
        tick();
        chk("map_pulse_end", 64'(map_valid_o), 64'd0);

        // LOAD_INSTR held with instr_ready low for 5 cycles
        instr_ready_i = 1'b0;
        send(mk(0, 21'h1ABCD));
        msg_valid_i = 1'b1;
        msg_data_i  = mk(2, sigp(9, 10, 3, 0));
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", 64'(instr_valid_o), 64'd1);
            chk("hold_data",  64'(instr_data_o),  64'h1ABCD);
            chk("hold_ready", 64'(msg_ready_o),   64'd0);
            tick();
        end
        instr_ready_i = 1'b1;
        #1;
        chk("drain_ready", 64'(msg_ready_o), 64'd1);
        tick();
        msg_valid_i = 1'b0;
        chk("drain_valid", 64'(instr_valid_o), 64'd0);
        chk("drain_sig",   64'(signal_valid_o), 64'd1);
        chk("drain_sig_row", 64'(signal_remote_row_o), 64'd9);
        tick();

        // Back-to-back SIG, CFG, SIG
        c0 = cyc;
        send(mk(2, sigp(1, 1, 1, 1)));
        chk("b2b_1", 64'({signal_valid_o, map_valid_o}), 64'b10);
        send(mk(1, cfgp(2, 0, 3, 3, 3, 1, 1, 0)));
        chk("b2b_2", 64'({signal_valid_o, map_valid_o}), 64'b01);
        send(mk(2, sigp(4, 5, 6, 0)));
        chk("b2b_3", 64'({signal_valid_o, map_valid_o}), 64'b10);
        chk("b2b_cycles", 64'(cyc - c0), 64'd3);
        tick();

        // 300 reserved commands saturate the drop counter
        msg_valid_i = 1'b1;
        for (int i = 0; i < 300; i++) begin
            msg_data_i = mk(3, PW'($urandom));
            tick();
        end
        msg_valid_i = 1'b0;
        chk("drop_sat", 64'(drop_count_o), 64'd255);
        tick();
        chk("drop_sat_hold", 64'(drop_count_o), 64'd255);

        // Async reset while an instruction is held
        instr_ready_i = 1'b0;
        send(mk(0, 21'h0F0F0));
        #2;
        rst_i = 1'b0;
        #1;
        chk("rst_mid_valid", 64'(instr_valid_o), 64'd0);
        chk("rst_mid_drop",  64'(drop_count_o),  64'd0);
        chk("rst_mid_ready", 64'(msg_ready_o),   64'd1);
        tick();
        rst_i = 1'b1;
        tick();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            msg_valid_i   = ($urandom_range(0, 3) != 0);
            msg_data_i    = mk((r < 3) ? 0 : (r < 6) ? 1 : (r < 9) ? 2 : 3, PW'($urandom));
            instr_ready_i = ($urandom_range(0, 1) != 0);
            rst_i         = ($urandom_range(0, 599) != 0);
            tick();
        end
        rst_i       = 1'b1;
        msg_valid_i = 1'b0;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
